int_alu_responder: RTL
======================

INT_ALU_RESPONDER -- requirements
Module: int_alu_responder

Interface
REQ-001 SHALL have parameter MODULE_ID, default 4'h3, bus module-select code this block answers to.
REQ-002 SHALL have parameter RES_W, default 32, result width before zero-extension to 256 bits.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 nReset  input  1  reset; asynchronous, active-low.
REQ-005 address  input  16  [15:12] module select, [11:0] register offset.
REQ-006 nRead  input  1  active-low read strobe from execution engine.
REQ-007 nWrite  input  1  active-low write strobe from execution engine.
REQ-008 ExeDataOut  input  256  write data from execution engine; only [15:0] used for operands, [7:0] for opcode.
REQ-009 IntDataOut  output  256  registered read data to execution engine.

Function
REQ-010 SHALL be selected only when address[15:12]==MODULE_ID; unselected cycles change no state and hold IntDataOut.
REQ-011 Selected write (nWrite=0 sampled at posedge): offset 0 -> SRC1<=ExeDataOut[15:0]; offset 1 -> SRC2<=ExeDataOut[15:0]; offset 3 -> execute with OPC=ExeDataOut[7:0]; other offsets ignored.
REQ-012 Execute SHALL load RESULT on the same edge that captures OPC, using SRC1/SRC2 as held before that edge.
REQ-013 Opcodes (unsigned): 8'h10 ADD -> SRC1+SRC2 (17-bit carry kept); 8'h11 SUB -> SRC1-SRC2, 16-bit wrap, zero-extended; 8'h12 MUL -> 32-bit product; 8'h13 DIV -> quotient in [15:0], remainder in [31:16].
REQ-014 DIV with SRC2==0 SHALL give RESULT=32'h0000_FFFF and set STATUS.DIVZ.
REQ-015 Any other opcode SHALL give RESULT=0 and set STATUS.BADOP.
REQ-016 Selected read (nRead=0 sampled at posedge, nWrite=1): IntDataOut<= offset 0 SRC1, 1 SRC2, 2 or 3 RESULT, 4 STATUS, else 0; all zero-extended to 256; valid the cycle after the strobe.
REQ-017 Op-then-read SHALL work back-to-back: opcode write cycle N, read strobe cycle N+1, IntDataOut=RESULT in cycle N+2.
REQ-018 nRead=0 and nWrite=0 together while selected: write performed, read ignored, IntDataOut held, STATUS.COLL set.
REQ-019 STATUS[15:0] = {OPCNT[11:0], STALE, COLL, BADOP, DIVZ}; flags sticky until next execute, which clears DIVZ/BADOP/STALE before setting the new ones; COLL cleared only by reset.
REQ-020 OPCNT SHALL increment per execute, wrapping 12'hFFF -> 0.
REQ-021 FSM states IDLE, HAVE1, HAVE2, ARMED, DONE: write SRC1 moves IDLE->HAVE1, HAVE2->ARMED; write SRC2 moves IDLE->HAVE2, HAVE1->ARMED; rewrites stay in state; execute from any state -> DONE; DONE+operand write -> HAVE1/HAVE2 accordingly.
REQ-022 Execute from any state other than ARMED SHALL still compute with current SRC1/SRC2 and set STATUS.STALE.

Reset
REQ-023 nReset low SHALL immediately clear SRC1, SRC2, OPC, RESULT, STATUS, OPCNT, IntDataOut to 0 and FSM to IDLE, including mid-transaction.
REQ-024 First posedge after nReset release SHALL be processed as a normal bus cycle.

Structure
REQ-025 Shared package SHALL hold module-select codes, offset constants (SRC1=0, SRC2=1, RES=2, OP=3, STAT=4), opcode constants, STATUS bit indices and the FSM enum.
REQ-026 Arithmetic SHALL live in one combinational sub-module int_alu_core (SRC1, SRC2, OPC -> RESULT, DIVZ, BADOP); bus decode, registers and FSM in the top.

Verification
REQ-027 Write SRC1=16'h0005, SRC2=16'h0003, OP=8'h10, read offset 3 next cycle -> IntDataOut=256'h8 two cycles after OP write, STATUS=16'h0010.
REQ-028 SRC1=16'hFFFF, SRC2=16'hFFFF, OP=8'h12 -> RESULT=32'hFFFE_0001; SUB SRC1=3, SRC2=5 -> RESULT=32'h0000_FFFE.
REQ-029 SRC1=16'h0064, SRC2=0, OP=8'h13 -> RESULT=32'h0000_FFFF, STATUS.DIVZ=1; then SRC2=7, OP=8'h13 -> RESULT=32'h0002_000E, DIVZ=0.
REQ-030 Write only SRC1 then OP=8'h10 -> STATUS.STALE=1; OP=8'h20 -> RESULT=0, BADOP=1.
REQ-031 Bus traffic with address[15:12]=4'h2 and 4'h0 (writes and reads) -> no register, FSM or IntDataOut change.
REQ-032 Assert nReset mid-sequence after SRC1 write -> all outputs 0, FSM IDLE; simultaneous nRead/nWrite=0 at offset 1 -> SRC2 written, IntDataOut held, COLL=1.

Source files
------------

// File: rtl/int_alu_responder_pkg.sv
// Shared constants for the integer ALU responder: module-select codes, register offsets,
// opcodes, STATUS bit positions and the operand-tracking FSM encoding.
package int_alu_responder_pkg;

  localparam logic [3:0] ModIdNone = 4'h0;
  localparam logic [3:0] ModIdAux  = 4'h2;
  localparam logic [3:0] ModIdAlu  = 4'h3;

  localparam logic [11:0] OffSrc1 = 12'd0;
  localparam logic [11:0] OffSrc2 = 12'd1;
  localparam logic [11:0] OffRes  = 12'd2;
  localparam logic [11:0] OffOp   = 12'd3;
  localparam logic [11:0] OffStat = 12'd4;

  localparam logic [7:0] OpAdd = 8'h10;
  localparam logic [7:0] OpSub = 8'h11;
  localparam logic [7:0] OpMul = 8'h12;
  localparam logic [7:0] OpDiv = 8'h13;

  localparam int unsigned StatDivz  = 0;
  localparam int unsigned StatBadop = 1;
  localparam int unsigned StatColl  = 2;
  localparam int unsigned StatStale = 3;
  localparam int unsigned StatOpcnt = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHave1,
    StHave2,
    StArmed,
    StDone
  } alu_state_e;

  function automatic logic [15:0] status_word(input logic [11:0] opcnt, input logic stale,
                                              input logic coll, input logic badop,
                                              input logic divz);
    return {opcnt, stale, coll, badop, divz};
  endfunction

endpackage

// File: rtl/int_alu_responder_if.sv
// Execution-engine register bus: module/offset address, active-low strobes, wide data paths.
interface int_alu_responder_if;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;
  logic [255:0] ExeDataOut;
  logic [255:0] IntDataOut;

  modport master (
    output address,
    output nRead,
    output nWrite,
    output ExeDataOut,
    input  IntDataOut
  );

  modport slave (
    input  address,
    input  nRead,
    input  nWrite,
    input  ExeDataOut,
    output IntDataOut
  );
endinterface

// File: rtl/int_alu_responder_core.sv
// Purely combinational unsigned arithmetic: ADD/SUB/MUL/DIV on two 16-bit operands,
// with divide-by-zero and illegal-opcode flags.
module int_alu_core
  import int_alu_responder_pkg::*;
#(
  parameter int unsigned RES_W = 32
) (
  input  logic [15:0]      src1,
  input  logic [15:0]      src2,
  input  logic [7:0]       opc,
  output logic [RES_W-1:0] result,
  output logic             divz,
  output logic             badop
);

  logic [31:0] res_full;
  logic [16:0] sum;
  logic [15:0] diff;

  assign sum  = {1'b0, src1} + {1'b0, src2};
  assign diff = src1 - src2;

  always_comb begin
    res_full = 32'h0;
    divz     = 1'b0;
    badop    = 1'b0;
    case (opc)
      OpAdd: res_full = {15'h0, sum};
      OpSub: res_full = {16'h0, diff};
      OpMul: res_full = {16'h0, src1} * {16'h0, src2};
      OpDiv: begin
        if (src2 == 16'h0) begin
          res_full = 32'h0000_FFFF;
          divz     = 1'b1;
        end else begin
          // Remainder in the upper half, quotient in the lower half.
          res_full = {src1 % src2, src1 / src2};
        end
      end
      default: badop = 1'b1;
    endcase
  end

  assign result = RES_W'(res_full);

endmodule

// File: rtl/int_alu_responder.sv
// Bus-mapped ALU responder: decodes its module-select slot, holds operands, result and
// STATUS, and tracks operand freshness with a small FSM.
module int_alu_responder
  import int_alu_responder_pkg::*;
#(
  parameter logic [3:0]  MODULE_ID = 4'h3,
  parameter int unsigned RES_W     = 32
) (
  input logic                 Clk,
  input logic                 nReset,
  int_alu_responder_if.slave  bus
);

  logic [15:0]      src1_q, src2_q;
  logic [7:0]       opc_q;
  logic [RES_W-1:0] result_q;
  logic [11:0]      opcnt_q;
  logic             divz_q, badop_q, coll_q, stale_q;
  logic [255:0]     rdata_q;
  alu_state_e       state_q;

  logic             sel, wr_en, rd_en;
  logic [11:0]      offset;
  logic [RES_W-1:0] core_result;
  logic             core_divz, core_badop;
  logic [15:0]      status;
  logic [255:0]     rd_mux;

  assign offset = bus.address[11:0];
  assign sel    = (bus.address[15:12] == MODULE_ID);
  assign wr_en  = sel && !bus.nWrite;
  assign rd_en  = sel && !bus.nRead && bus.nWrite;
  assign status = status_word(opcnt_q, stale_q, coll_q, badop_q, divz_q);

  // Opcode comes straight off the bus so the result lands on the capturing edge.
  int_alu_core #(
    .RES_W (RES_W)
  ) u_core (
    .src1   (src1_q),
    .src2   (src2_q),
    .opc    (bus.ExeDataOut[7:0]),
    .result (core_result),
    .divz   (core_divz),
    .badop  (core_badop)
  );

  always_comb begin
    rd_mux = '0;
    case (offset)
      OffSrc1:        rd_mux = 256'(src1_q);
      OffSrc2:        rd_mux = 256'(src2_q);
      OffRes, OffOp:  rd_mux = 256'(result_q);
      OffStat:        rd_mux = 256'(status);
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      src1_q   <= '0;
      src2_q   <= '0;
      opc_q    <= '0;
      result_q <= '0;
      opcnt_q  <= '0;
      divz_q   <= 1'b0;
      badop_q  <= 1'b0;
      coll_q   <= 1'b0;
      stale_q  <= 1'b0;
      rdata_q  <= '0;
      state_q  <= StIdle;
    end else if (wr_en) begin
      if (!bus.nRead) coll_q <= 1'b1;
      case (offset)
        OffSrc1: begin
          src1_q <= bus.ExeDataOut[15:0];
          case (state_q)
            StIdle, StDone: state_q <= StHave1;
            StHave2:        state_q <= StArmed;
            default:        state_q <= state_q;
          endcase
        end
        OffSrc2: begin
          src2_q <= bus.ExeDataOut[15:0];
          case (state_q)
            StIdle, StDone: state_q <= StHave2;
            StHave1:        state_q <= StArmed;
            default:        state_q <= state_q;
          endcase
        end
        OffOp: begin
          opc_q    <= bus.ExeDataOut[7:0];
          result_q <= core_result;
          divz_q   <= core_divz;
          badop_q  <= core_badop;
          stale_q  <= (state_q != StArmed);
          opcnt_q  <= opcnt_q + 12'd1;
          state_q  <= StDone;
        end
        default: ;
      endcase
    end else if (rd_en) begin
      rdata_q <= rd_mux;
    end
  end

  assign bus.IntDataOut = rdata_q;

  // OPC is kept for completeness but not exposed on the read map.
  logic unused_bits;
  assign unused_bits = ^{bus.ExeDataOut[255:16], opc_q};

endmodule
